// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: pulls frame_len words from a valid/ready word
// port and emits them on a registered AXI-Stream master, tlast on the final word.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  word_cnt,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q;
  logic                   out_hs;
  logic                   accept;
  logic                   in_ready_c;

  assign out_hs = tvalid_q & m_axis_tready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            len_d   = frame_len;
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        // One-entry output register: refill allowed when empty or draining this cycle.
        in_ready_c = !tvalid_q || m_axis_tready;
        accept     = in_valid && in_ready_c;
        if (out_hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        if (accept) begin
          tdata_d  = in_data;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == len_q - ONE);
          cnt_d    = cnt_q + ONE;
          if (cnt_q == len_q - ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign word_cnt      = cnt_q;
  assign in_ready      = in_ready_c;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Bench for axis_frame_tx: randomized producer/consumer traffic compared against
// an in-order word queue with tlast on the final word and done one cycle later.
module tb_axis_frame_tx;
  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          busy, done, err;
  logic [LW-1:0] word_cnt;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] tdata;
  logic          tlast, tvalid, tready;

  axis_frame_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] words[$];
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  logic [DW-1:0] sent[$];
  bit            busy_log[$];
  int done_cnt, done_cyc, last_hs_cyc, stall_viol, rdy_viol, err_cnt, busy_viol;
  bit timed_out;

  // Frame payload: words[0..len-1] plus one surplus word the producer keeps offering.
  task automatic make_words(input int len, input bit seq);
    words.delete();
    for (int i = 0; i <= len; i++) words.push_back(seq ? DW'(i + 1) : {$urandom, $urandom});
  endtask

  // Issues start, then runs producer/consumer per cycle and records what the DUT did.
  task automatic run_frame(input int len, input int gap_mode, input int rdy_mode,
                           input int st1, input int st2);
    int idx, tail;
    bit offering, prev_stall, prev_l;
    logic [DW-1:0] prev_d;
    obs_data.delete(); obs_last.delete(); sent.delete(); busy_log.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    stall_viol = 0; rdy_viol = 0; err_cnt = 0; busy_viol = 0;
    start = 1'b1; frame_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; offering = 1'b0; prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
    tail = -1; timed_out = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start     = (cyc == st1) || (cyc == st2);
      frame_len = (cyc == st2) ? LW'(0) : LW'(7);
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tready = 1'($urandom % 2);
      endcase
      if (!offering && idx <= len) begin
        if (gap_mode == 0 || (gap_mode == 1 && cyc % 2 == 0) ||
            (gap_mode == 2 && $urandom % 2 == 1)) offering = 1'b1;
      end
      in_valid = offering;
      in_data  = offering ? words[idx] : '0;
      #1;
      if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l)) stall_viol++;
      if (tvalid === 1'b1 && !tready && in_ready !== 1'b0) rdy_viol++;
      prev_stall = (tvalid === 1'b1) && !tready;
      prev_d = tdata; prev_l = tlast;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (tail < 0) tail = cyc + 2;
      end
      busy_log.push_back(busy);
      if (tvalid === 1'b1 && tready) begin
        obs_data.push_back(tdata);
        obs_last.push_back(tlast);
        if (tlast) last_hs_cyc = cyc;
      end
      if (in_valid && in_ready === 1'b1) begin
        sent.push_back(in_data);
        idx++;
        offering = 1'b0;
      end
      @(posedge clk); #1;
      if (tail >= 0 && cyc >= tail) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; tready = 1'b0;
    // busy is expected high from the first cycle until the cycle after the last handshake
    for (int i = 0; i < busy_log.size(); i++)
      if (busy_log[i] != (last_hs_cyc < 0 || i <= last_hs_cyc)) busy_viol++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, word_cnt, tvalid, tlast, tdata, in_ready} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b err=%b cnt=%0d tvalid=%b tlast=%b tdata=%h in_ready=%b want all 0",
               busy, done, err, word_cnt, tvalid, tlast, tdata, in_ready);
    else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    int acc, bad;
    bit hs;
    make_words(5, 1'b1);
    start = 1'b1; frame_len = LW'(5);
    @(posedge clk); #1;
    start = 1'b0; tready = 1'b1; acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      in_valid = 1'b1; in_data = words[acc];
      #1; hs = (in_ready === 1'b1);
      @(posedge clk); #1;
      if (hs) acc++;
    end
    checks++;
    if (acc !== 2) $display("FAIL rst_mid_accepts: got %0d want 2", acc); else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, word_cnt, tvalid, tlast, tdata, in_ready} !== '0)
      $display("FAIL rst_mid_clear: got busy=%b done=%b err=%b cnt=%0d tvalid=%b tlast=%b tdata=%h in_ready=%b want all 0",
               busy, done, err, word_cnt, tvalid, tlast, tdata, in_ready);
    else passes++;
    in_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (tvalid !== 1'b0 || done !== 1'b0 || tlast !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d cycles with output activity want 0", bad); else passes++;
    make_words(3, 1'b0);
    run_frame(3, 0, 0, -1, -1);
    checks++;
    if (timed_out || obs_data.size() !== 3 || done_cnt !== 1)
      $display("FAIL rst_mid_next_frame: got beats=%0d done=%0d timeout=%b want beats=3 done=1 timeout=0",
               obs_data.size(), done_cnt, timed_out);
    else passes++;
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      checks++;
      if (obs_data[i] !== words[i] || obs_last[i] !== (i == 2))
        $display("FAIL rst_mid_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], words[i], i == 2);
      else passes++;
    end
  endtask

  task automatic test_basic;
    make_words(4, 1'b1);
    run_frame(4, 0, 0, -1, -1);
    checks++;
    if (timed_out || obs_data.size() !== 4 || sent.size() !== 4)
      $display("FAIL basic_count: got beats=%0d accepted=%0d timeout=%b want 4/4/0", obs_data.size(), sent.size(), timed_out);
    else passes++;
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      checks++;
      if (obs_data[i] !== words[i] || obs_last[i] !== (i == 3))
        $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], words[i], i == 3);
      else passes++;
    end
    checks++;
    if (done_cnt !== 1 || last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1)
      $display("FAIL basic_done: got count=%0d at cycle %0d want 1 at cycle %0d", done_cnt, done_cyc, last_hs_cyc + 1);
    else passes++;
    checks++;
    if (busy_viol !== 0 || word_cnt !== LW'(4))
      $display("FAIL basic_busy_cnt: got busy errors=%0d word_cnt=%0d want 0 and 4", busy_viol, word_cnt);
    else passes++;
  endtask

  task automatic test_stall;
    make_words(4, 1'b0);
    run_frame(4, 0, 1, -1, -1);
    checks++;
    if (stall_viol !== 0 || rdy_viol !== 0)
      $display("FAIL stall_hold: got unstable=%0d in_ready_while_stalled=%0d want 0/0", stall_viol, rdy_viol);
    else passes++;
    checks++;
    if (timed_out || obs_data.size() !== 4 || sent.size() !== 4)
      $display("FAIL stall_count: got beats=%0d accepted=%0d timeout=%b want 4/4/0", obs_data.size(), sent.size(), timed_out);
    else passes++;
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      checks++;
      if (obs_data[i] !== words[i] || obs_last[i] !== (i == 3))
        $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], words[i], i == 3);
      else passes++;
    end
    checks++;
    if (done_cnt !== 1 || last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1)
      $display("FAIL stall_done: got count=%0d at cycle %0d want 1 at cycle %0d", done_cnt, done_cyc, last_hs_cyc + 1);
    else passes++;
  endtask

  task automatic test_len1_and_err;
    make_words(1, 1'b0);
    run_frame(1, 0, 2, -1, -1);
    checks++;
    if (timed_out || obs_data.size() !== 1 || sent.size() !== 1)
      $display("FAIL len1_count: got beats=%0d accepted=%0d timeout=%b want 1/1/0", obs_data.size(), sent.size(), timed_out);
    else passes++;
    if (obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== words[0] || obs_last[0] !== 1'b1)
        $display("FAIL len1_beat: got %h/%b want %h/1", obs_data[0], obs_last[0], words[0]);
      else passes++;
    end
    checks++;
    if (done_cnt !== 1 || last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1 || busy_viol !== 0)
      $display("FAIL len1_done: got count=%0d at cycle %0d busy errors=%0d want 1 at cycle %0d, 0",
               done_cnt, done_cyc, busy_viol, last_hs_cyc + 1);
    else passes++;
    start = 1'b1; frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err_pulse: got err=%b busy=%b want 1/0", err, busy);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0)
      $display("FAIL err_one_cycle: got err=%b busy=%b want 0/0", err, busy);
    else passes++;
  endtask

  task automatic test_ignore_start;
    make_words(3, 1'b1);
    run_frame(3, 0, 0, 1, 3);
    checks++;
    if (timed_out || obs_data.size() !== 3 || done_cnt !== 1 || err_cnt !== 0)
      $display("FAIL ignore_start: got beats=%0d done=%0d err=%0d timeout=%b want 3/1/0/0",
               obs_data.size(), done_cnt, err_cnt, timed_out);
    else passes++;
    checks++;
    if (word_cnt !== LW'(3))
      $display("FAIL ignore_start_cnt: got %0d want 3", word_cnt);
    else passes++;
  endtask

  task automatic test_gaps;
    make_words(6, 1'b1);
    run_frame(6, 1, 2, -1, -1);
    checks++;
    if (timed_out || obs_data.size() !== 6 || sent.size() !== 6 || stall_viol !== 0)
      $display("FAIL gaps_count: got beats=%0d accepted=%0d unstable=%0d timeout=%b want 6/6/0/0",
               obs_data.size(), sent.size(), stall_viol, timed_out);
    else passes++;
    for (int i = 0; i < obs_data.size() && i < 6; i++) begin
      checks++;
      if (obs_data[i] !== words[i] || obs_last[i] !== (i == 5))
        $display("FAIL gaps_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], words[i], i == 5);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int len;
    for (int f = 0; f < 6; f++) begin
      len = 1 + int'($urandom % 12);
      make_words(len, 1'b0);
      run_frame(len, 2, 2, -1, -1);
      checks++;
      if (timed_out || obs_data.size() !== len || sent.size() !== len || done_cnt !== 1 ||
          done_cyc !== last_hs_cyc + 1 || stall_viol !== 0 || rdy_viol !== 0 || busy_viol !== 0)
        $display("FAIL b2b_frame%0d: got beats=%0d acc=%0d done=%0d@%0d unstable=%0d rdy=%0d busy=%0d want %0d/%0d/1@%0d/0/0/0",
                 f, obs_data.size(), sent.size(), done_cnt, done_cyc, stall_viol, rdy_viol, busy_viol,
                 len, len, last_hs_cyc + 1);
      else passes++;
      for (int i = 0; i < obs_data.size() && i < len; i++) begin
        checks++;
        if (obs_data[i] !== words[i] || obs_last[i] !== (i == len - 1))
          $display("FAIL b2b_frame%0d_beat%0d: got %h/%b want %h/%b", f, i, obs_data[i], obs_last[i],
                   words[i], i == len - 1);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_frame;
    test_basic;
    test_stall;
    test_len1_and_err;
    test_ignore_start;
    test_gaps;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
